register_pipe: RTL and testbench
================================

Name: register_pipe

Overview:
- Parametrised elastic pipeline register: a chain of DEPTH valid/ready stages carrying WORD_WIDTH-bit words.
- An optional input skid buffer registers the upstream ready signal, so no combinational path runs from m_ready to s_ready.
- Used wherever a datapath needs retiming stages with backpressure. It replaces hand-placed plain registers plus ad hoc valid tracking.

Parameters:
- WORD_WIDTH, 8: data width in bits; must be >= 1.
- DEPTH, 2: number of pipeline stages; must be >= 1. DEPTH = 0 is an elaboration error.
- RESET_VALUE, 0: value loaded into every data register on reset and on clear.
- SKID, 1: 1 = registered s_ready through a one-entry input skid buffer; 0 = combinational ready chain.

Ports:
- clock  in  1  single clock; all state changes on its rising edge except reset.
- resetn  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active high.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  block can accept a word.
- s_data  in  WORD_WIDTH  upstream word.
- m_valid  out  1  downstream word valid (last stage valid).
- m_ready  in  1  downstream accepts.
- m_data  out  WORD_WIDTH  downstream word (last stage data).
- count  out  $clog2(DEPTH+SKID+1)  number of words currently held.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clock, resetn).
- Transfer rules:
  - A transfer occurs on a side when valid && ready at a rising edge.
  - valid must not depend on ready.
  - Once valid is asserted, data is held until the transfer completes; the block obeys this on m_*.
- Stage i advance: stage i advances when valid_i && (stage i+1 empty || stage i+1 advancing). The last stage advances on m_ready.
- Stage i load: stage i loads when it is empty or advancing.
- Data registers load only on a transfer into them. Their content while not valid is don't-care, except after reset or clear.
- SKID=0:
  - s_ready = stage 0 can load (combinational).
  - Capacity DEPTH words.
- SKID=1:
  - s_ready is a register equal to "skid empty", ANDed with registered reset-release flag rst_done.
  - Input word goes directly to stage 0 if stage 0 can load; otherwise it goes to the skid.
  - While the skid is full, stage 0 loads from the skid, never from s_data.
  - s_ready drops the cycle after the skid fills and rises the cycle after it drains.
  - Capacity DEPTH+1 words.
- Latency and throughput:
  - Empty pipe: word accepted at edge t appears on m_valid/m_data after edge t+DEPTH-1, i.e. DEPTH cycles of latency.
  - The skid adds no latency when empty.
  - Sustained throughput is 1 word/cycle with no bubbles when m_ready is held high.
  - Order is strictly preserved.
- count (registered):
  - count_next = count + in_xfer - out_xfer.
  - Never exceeds DEPTH+SKID and never underflows.
- Reset (resetn low, asynchronous, no clock needed):
  - All valids = 0, m_valid = 0, skid empty.
  - All data registers = RESET_VALUE, count = 0.
  - rst_done = 0, so s_ready = 0.
  - rst_done sets at the first rising edge with resetn high; s_ready = 1 from then on (SKID=1).
  - SKID=0: s_ready = 1 whenever resetn is high.
- Reset mid-operation: all held words are discarded immediately; outputs take reset values without waiting for a clock edge.
- clear (synchronous, priority over all transfers):
  - At the edge: all valids and the skid = 0, data = RESET_VALUE, count = 0.
  - An input handshake in the clear cycle is discarded. Upstream holds off if the word matters.
  - An output handshake in the clear cycle completes; the consumer keeps that word.
- Simultaneous in and out transfer on a full pipe: allowed, count unchanged. SKID=1 keeps s_ready low until the skid drains.

Test Plan (WORD_WIDTH=8, DEPTH=3, SKID=1, RESET_VALUE=0x5A unless stated):
- Reset: resetn low, no clock edges -> m_valid=0, m_data=0x5A, s_ready=0, count=0. Release resetn -> s_ready=1 after the first rising edge.
- Streaming: m_ready=1, push 0x01..0x10 back-to-back -> 0x01 on m_data 3 cycles after its accept, then one word per cycle in order, no bubbles, count steady at 3.
- Backpressure: m_ready=0, s_valid=1 with 0xA0,0xA1,... -> exactly 0xA0..0xA3 accepted, s_ready=0 from the cycle after the 4th accept, count=4. Raise m_ready -> 0xA0..0xA3 out in order, s_ready=1 the cycle after the skid empties.
- Clear: count=4, s_valid=1 with 0xB0, clear pulsed for one cycle -> next cycle count=0, m_valid=0, m_data=0x5A. 0xB0 never emerges; subsequent 0xB1 emerges after 3 cycles.
- Async reset mid-stream: resetn low between edges with count=3 -> m_valid=0 and count=0 before the next edge; after release, stream resumes cleanly.
- Random: 10k words, random s_valid/m_ready, both SKID=0 and SKID=1, DEPTH=1 and DEPTH=4 -> scoreboard matches exactly, count equals the reference occupancy, count <= DEPTH+SKID, m_data stable while m_valid && !m_ready.

Source files
------------

// File: rtl/register_pipe.sv
// register_pipe: elastic valid/ready pipeline of DEPTH stages carrying
// WORD_WIDTH-bit words. With SKID=1, a one-entry input skid buffer makes
// s_ready a pure register output, so there is no combinational path from
// m_ready to s_ready. count reports how many words the block holds.
module register_pipe #(
    parameter int                    WORD_WIDTH  = 8,
    parameter int                    DEPTH       = 2,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    SKID        = 1,
    localparam int                   CW          = $clog2(DEPTH + SKID + 1)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic [CW-1:0]         count
);

    generate
        if (WORD_WIDTH < 1 || DEPTH < 1 || (SKID != 0 && SKID != 1)) begin : g_param_check
            $error("register_pipe: WORD_WIDTH>=1, DEPTH>=1 and SKID in {0,1} required");
        end
    endgenerate

    logic [DEPTH-1:0]      r_valid;
    logic [WORD_WIDTH-1:0] r_data [DEPTH];
    logic [CW-1:0]         r_count;

    logic [DEPTH-1:0]      w_adv;        // stage i hands its word onward this cycle
    logic [DEPTH-1:0]      w_load;       // stage i can take a new word this cycle
    logic                  w_src_valid;  // a word is offered to stage 0
    logic [WORD_WIDTH-1:0] w_src_data;
    logic                  w_take0;
    logic                  w_in_xfer;
    logic                  w_out_xfer;

    // Walk from the output back to stage 0: a stage has room when it is
    // empty or its word is leaving, and that room is what the stage before sees.
    always_comb begin
        logic v_room;
        logic v_adv;
        // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
        w_adv  = '0;
        w_load = '0;
        v_room = m_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            v_adv     = r_valid[i] && v_room;
            w_adv[i]  = v_adv;
            w_load[i] = !r_valid[i] || v_adv;
            v_room    = !r_valid[i] || v_adv;
        end
    end

    assign w_take0    = w_src_valid && w_load[0];
    assign w_in_xfer  = s_valid && s_ready;
    assign w_out_xfer = m_valid && m_ready;

    // Stage registers: valid bits track occupancy, data moves only on a transfer.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the data array is reset on purpose; RESET_VALUE must be visible on m_data after reset and clear.
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VALUE;
        end else if (clear) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VALUE;
        end else begin
            // NOTE: non-blocking assignments make every stage sample its neighbour's pre-edge value.
            if (w_take0) begin
                r_valid[0] <= 1'b1;
                r_data[0]  <= w_src_data;
            end else if (w_adv[0]) begin
                r_valid[0] <= 1'b0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i-1]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= r_data[i-1];
                end else if (w_adv[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Occupancy counter: +1 per accepted word, -1 per delivered word.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic                  r_skid_valid;
            logic [WORD_WIDTH-1:0] r_skid_data;
            logic                  r_rst_done;

            // Reset-release flag: holds s_ready low until the first edge out of reset.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) r_rst_done <= 1'b0;
                else         r_rst_done <= 1'b1;
            end

            // Skid entry: catches a word accepted while stage 0 is blocked and
            // feeds stage 0 ahead of s_data until it drains.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= RESET_VALUE;
                end else if (clear) begin
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= RESET_VALUE;
                end else if (r_skid_valid) begin
                    if (w_load[0]) r_skid_valid <= 1'b0;
                end else if (w_in_xfer && !w_load[0]) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= s_data;
                end
            end

            assign s_ready     = r_rst_done && !r_skid_valid;
            assign w_src_valid = r_skid_valid || w_in_xfer;
            assign w_src_data  = r_skid_valid ? r_skid_data : s_data;
        end else begin : g_no_skid
            assign s_ready     = w_load[0] && resetn;
            assign w_src_valid = s_valid;
            assign w_src_data  = s_data;
        end
    endgenerate

    assign m_valid = r_valid[DEPTH-1];
    assign m_data  = r_data[DEPTH-1];
    assign count   = r_count;

endmodule

// File: tb/tb_register_pipe.sv
// Testbench for register_pipe: directed vector table on the main instance
// (DEPTH=3, SKID=1, RESET_VALUE=0x5A), hand sequences for reset corners,
// then a randomised scoreboard run over three configurations.
module tb_register_pipe;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       clr;
        logic       emv;
        logic [7:0] emd;
        logic       esr;
        int         ecnt;
    } vec_t;

    logic       clock  = 1'b0;
    logic       clk_en = 1'b0;
    logic       resetn = 1'b1;
    logic       clear  = 1'b0;

    logic       sv  [3];
    logic [7:0] sd  [3];
    logic       mr  [3];
    logic       srd [3];
    logic       mv  [3];
    logic [7:0] md  [3];
    logic [2:0] cnt0;
    logic [2:0] cnt1;
    logic [1:0] cnt2;

    int checks   = 0;
    int failures = 0;

    register_pipe #(.WORD_WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h5A), .SKID(1)) u_d3s1 (
        .clock(clock), .resetn(resetn), .clear(clear),
        .s_valid(sv[0]), .s_ready(srd[0]), .s_data(sd[0]),
        .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]), .count(cnt0));

    register_pipe #(.WORD_WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h5A), .SKID(0)) u_d4s0 (
        .clock(clock), .resetn(resetn), .clear(clear),
        .s_valid(sv[1]), .s_ready(srd[1]), .s_data(sd[1]),
        .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]), .count(cnt1));

    register_pipe #(.WORD_WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h5A), .SKID(1)) u_d1s1 (
        .clock(clock), .resetn(resetn), .clear(clear),
        .s_valid(sv[2]), .s_ready(srd[2]), .s_data(sd[2]),
        .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]), .count(cnt2));

    always begin
        #5;
        if (clk_en) clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sv_, input logic [7:0] sd_, input logic mr_,
                                input logic clr_, input logic emv_, input logic [7:0] emd_,
                                input logic esr_, input int ecnt_);
        vec_t v;
        v.sv = sv_;  v.sd = sd_;  v.mr = mr_;  v.clr = clr_;
        v.emv = emv_; v.emd = emd_; v.esr = esr_; v.ecnt = ecnt_;
        return v;
    endfunction

    // Drive one cycle of inputs on the main instance, compare mid-cycle, then clock.
    task automatic apply(input vec_t v, input string tag, input int row);
        sv[0] = v.sv;
        sd[0] = v.sd;
        mr[0] = v.mr;
        clear = v.clr;
        @(negedge clock);
        check($sformatf("%s[%0d].m_valid", tag, row), 32'(mv[0]),  32'(v.emv));
        check($sformatf("%s[%0d].m_data",  tag, row), 32'(md[0]),  32'(v.emd));
        check($sformatf("%s[%0d].s_ready", tag, row), 32'(srd[0]), 32'(v.esr));
        check($sformatf("%s[%0d].count",   tag, row), 32'(cnt0),   32'(v.ecnt));
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    function automatic int get_cnt(input int k);
        case (k)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    initial begin
        vec_t       tbl[$];
        vec_t       seq[$];
        logic [7:0] sb [3][$];
        int         got  [3];
        int         cap  [3];
        logic       hold [3];
        logic       stall[3];
        logic [7:0] pmd  [3];
        int         cyc;
        logic [7:0] exp_d;
        int         c;

        for (int k = 0; k < 3; k++) begin
            sv[k] = 1'b0; sd[k] = 8'h00; mr[k] = 1'b0;
        end

        // ---- Reset with no clock edges ----
        #1 resetn = 1'b0;
        #2;
        check("reset.m_valid", 32'(mv[0]),  32'd0);
        check("reset.m_data",  32'(md[0]),  32'h5A);
        check("reset.s_ready", 32'(srd[0]), 32'd0);
        check("reset.count",   32'(cnt0),   32'd0);
        check("reset.skid0.s_ready", 32'(srd[1]), 32'd0);

        clk_en = 1'b1;
        repeat (2) @(posedge clock);
        #1 check("reset_held.s_ready", 32'(srd[0]), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("release.s_ready_before_edge", 32'(srd[0]), 32'd0);
        check("release.skid0.s_ready",       32'(srd[1]), 32'd1);
        @(posedge clock);
        #1;
        check("release.s_ready_after_edge",  32'(srd[0]), 32'd1);
        check("release.d1s1.s_ready",        32'(srd[2]), 32'd1);

        // ---- Streaming 0x01..0x10 with m_ready high ----
        for (int n = 0; n <= 18; n++) begin
            tbl.push_back(mk(n <= 15, 8'(n + 1), 1'b1, 1'b0,
                             n >= 3, (n < 3) ? 8'h5A : 8'(n - 2), 1'b1,
                             (n <= 2) ? n : ((n <= 16) ? 3 : 19 - n)));
        end
        // ---- Backpressure: four words fit, then s_ready drops ----
        tbl.push_back(mk(1, 8'hA0, 0, 0, 0, 8'h10, 1, 0));
        tbl.push_back(mk(1, 8'hA1, 0, 0, 0, 8'h10, 1, 1));
        tbl.push_back(mk(1, 8'hA2, 0, 0, 0, 8'h10, 1, 2));
        tbl.push_back(mk(1, 8'hA3, 0, 0, 1, 8'hA0, 1, 3));
        tbl.push_back(mk(1, 8'hA4, 0, 0, 1, 8'hA0, 0, 4));
        tbl.push_back(mk(1, 8'hA4, 0, 0, 1, 8'hA0, 0, 4));
        tbl.push_back(mk(1, 8'hA4, 1, 0, 1, 8'hA0, 0, 4));
        tbl.push_back(mk(0, 8'hA4, 1, 0, 1, 8'hA1, 1, 3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA2, 1, 2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA3, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'hA3, 1, 0));
        // ---- Clear on a full pipe; 0xB0 offered during clear never emerges ----
        tbl.push_back(mk(1, 8'hC0, 0, 0, 0, 8'hA3, 1, 0));
        tbl.push_back(mk(1, 8'hC1, 0, 0, 0, 8'hA3, 1, 1));
        tbl.push_back(mk(1, 8'hC2, 0, 0, 0, 8'hA3, 1, 2));
        tbl.push_back(mk(1, 8'hC3, 0, 0, 1, 8'hC0, 1, 3));
        tbl.push_back(mk(1, 8'hB0, 0, 1, 1, 8'hC0, 0, 4));
        tbl.push_back(mk(1, 8'hB1, 0, 0, 0, 8'h5A, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h5A, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h5A, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'hB1, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'hB1, 1, 0));
        // ---- Clear with both handshakes live: D0 delivered, D3 discarded ----
        tbl.push_back(mk(1, 8'hD0, 0, 0, 0, 8'hB1, 1, 0));
        tbl.push_back(mk(1, 8'hD1, 0, 0, 0, 8'hB1, 1, 1));
        tbl.push_back(mk(1, 8'hD2, 0, 0, 0, 8'hB1, 1, 2));
        tbl.push_back(mk(1, 8'hD3, 1, 1, 1, 8'hD0, 1, 3));
        for (int n = 0; n < 4; n++) tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h5A, 1, 0));

        foreach (tbl[i]) apply(tbl[i], "tbl", i);

        // ---- Asynchronous reset mid-stream ----
        apply(mk(1, 8'hE0, 0, 0, 0, 8'h5A, 1, 0), "arst_fill", 0);
        apply(mk(1, 8'hE1, 0, 0, 0, 8'h5A, 1, 1), "arst_fill", 1);
        apply(mk(1, 8'hE2, 0, 0, 0, 8'h5A, 1, 2), "arst_fill", 2);
        sv[0] = 1'b0;
        mr[0] = 1'b1;
        #1;
        check("arst.pre.count",   32'(cnt0),  32'd3);
        check("arst.pre.m_data",  32'(md[0]), 32'hE0);
        #1 resetn = 1'b0;
        #1;
        check("arst.m_valid", 32'(mv[0]),  32'd0);
        check("arst.m_data",  32'(md[0]),  32'h5A);
        check("arst.s_ready", 32'(srd[0]), 32'd0);
        check("arst.count",   32'(cnt0),   32'd0);
        #2 resetn = 1'b1;
        #1 check("arst.release.s_ready", 32'(srd[0]), 32'd0);
        @(posedge clock);
        #1;
        seq.push_back(mk(1, 8'hF0, 1, 0, 0, 8'h5A, 1, 0));
        seq.push_back(mk(1, 8'hF1, 1, 0, 0, 8'h5A, 1, 1));
        seq.push_back(mk(0, 8'h00, 1, 0, 0, 8'h5A, 1, 2));
        seq.push_back(mk(0, 8'h00, 1, 0, 1, 8'hF0, 1, 2));
        seq.push_back(mk(0, 8'h00, 1, 0, 1, 8'hF1, 1, 1));
        seq.push_back(mk(0, 8'h00, 1, 0, 0, 8'hF1, 1, 0));
        foreach (seq[i]) apply(seq[i], "arst_resume", i);

        // ---- Random traffic on all three configurations ----
        cap[0] = 4; cap[1] = 4; cap[2] = 2;
        for (int k = 0; k < 3; k++) begin
            got[k] = 0; hold[k] = 1'b0; stall[k] = 1'b0; pmd[k] = 8'h00;
        end
        cyc = 0;
        while (cyc < 40000 && !(got[0] >= 10000 && got[1] >= 10000 && got[2] >= 10000)) begin
            for (int k = 0; k < 3; k++) begin
                if (!hold[k]) begin
                    sv[k] = ($urandom_range(0, 3) != 0);
                    sd[k] = 8'($urandom);
                end
                mr[k] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                c = get_cnt(k);
                check($sformatf("rnd%0d.count", k), 32'(c), 32'(sb[k].size()));
                check($sformatf("rnd%0d.count_le_cap", k), 32'(c <= cap[k]), 32'd1);
                if (stall[k]) begin
                    check($sformatf("rnd%0d.hold_valid", k), 32'(mv[k]), 32'd1);
                    check($sformatf("rnd%0d.hold_data", k),  32'(md[k]), 32'(pmd[k]));
                end
                if (mv[k] && mr[k]) begin
                    check($sformatf("rnd%0d.pop_nonempty", k), 32'(sb[k].size() > 0), 32'd1);
                    if (sb[k].size() > 0) begin
                        exp_d = sb[k].pop_front();
                        check($sformatf("rnd%0d.data", k), 32'(md[k]), 32'(exp_d));
                    end
                    got[k]++;
                end
                if (sv[k] && srd[k]) sb[k].push_back(sd[k]);
                hold[k]  = sv[k] && !srd[k];
                stall[k] = mv[k] && !mr[k];
                pmd[k]   = md[k];
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        check("rnd.completed_within_budget",
              32'(got[0] >= 10000 && got[1] >= 10000 && got[2] >= 10000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
